// File: rtl/core_pkg.sv
// Shared encodings and the scoreboard record type for the pipeline hazard logic.
package core_pkg;

  localparam int RA_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_SRC_MEM = 2'b01;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            is_load;
    logic            is_mem;
  } sb_rec_t;

  localparam sb_rec_t SB_EMPTY = '0;

  // x0 writes are architecturally discarded, so they never produce a value
  function automatic logic sb_writer(input sb_rec_t r);
    return r.valid && r.reg_write && (r.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select for the EX stage; the youngest producer (MEM) wins over WB.
module hazard_fwd_sel
  import core_pkg::*;
(
  input  sb_rec_t         mem_rec,
  input  sb_rec_t         wb_rec,
  input  logic [RA_W-1:0] ex_rs,
  input  logic            ex_use,
  output logic [1:0]      fwd_sel
);

  logic unused_fields;
  assign unused_fields = mem_rec.is_mem ^ wb_rec.is_load ^ wb_rec.is_mem;

  // a load in MEM has no data yet; that case is covered by the load-use bubble
  always_comb begin
    fwd_sel = FWD_REG;
    if (ex_use && sb_writer(mem_rec) && !mem_rec.is_load && (mem_rec.rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (ex_use && sb_writer(wb_rec) && (wb_rec.rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush/forwarding controller for the 5-stage core, tracking EX/MEM/WB in a scoreboard.
// Build option HAZARD_FWD_EN: defined -> forwarding + load-use stall; undefined -> RAW stall, no forwarding.
module hazard_sequencer
  import core_pkg::*;
#(
  parameter int REG_ADDR_W = RA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_reg_write,
  input  logic [1:0]            id_result_src,
  input  logic                  id_mem_write,
  input  logic                  ex_redirect,
  input  logic                  dmem_ready,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  stall_w,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e
);

  sb_rec_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  sb_rec_t id_rec;

  logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
  logic                  ex_use_rs1_q, ex_use_rs1_d, ex_use_rs2_q, ex_use_rs2_d;

  logic mem_wait;
  logic id_hit_ex;
  logic hazard;
  logic ex_bubble;

  always_comb begin
    id_rec           = SB_EMPTY;
    id_rec.valid     = id_valid;
    id_rec.rd        = id_rd;
    id_rec.reg_write = id_reg_write;
    id_rec.is_load   = (id_result_src == RES_SRC_MEM);
    id_rec.is_mem    = (id_result_src == RES_SRC_MEM) || id_mem_write;
  end

  assign mem_wait  = mem_q.valid && mem_q.is_mem && !dmem_ready;
  assign id_hit_ex = id_valid && sb_writer(ex_q) &&
                     ((id_use_rs1 && (id_rs1 == ex_q.rd)) || (id_use_rs2 && (id_rs2 == ex_q.rd)));

`ifdef HAZARD_FWD_EN
  assign hazard = id_hit_ex && ex_q.is_load;

  hazard_fwd_sel u_fwd_a (
    .mem_rec (mem_q),
    .wb_rec  (wb_q),
    .ex_rs   (ex_rs1_q),
    .ex_use  (ex_use_rs1_q),
    .fwd_sel (fwd_a_e)
  );

  hazard_fwd_sel u_fwd_b (
    .mem_rec (mem_q),
    .wb_rec  (wb_q),
    .ex_rs   (ex_rs2_q),
    .ex_use  (ex_use_rs2_q),
    .fwd_sel (fwd_b_e)
  );
`else
  logic id_hit_mem;
  logic unused_fwd_state;

  assign id_hit_mem = id_valid && sb_writer(mem_q) &&
                      ((id_use_rs1 && (id_rs1 == mem_q.rd)) || (id_use_rs2 && (id_rs2 == mem_q.rd)));
  // without bypass paths, ID waits until the producer reaches WB (write-before-read regfile)
  assign hazard     = id_hit_ex || id_hit_mem;
  assign fwd_a_e    = FWD_REG;
  assign fwd_b_e    = FWD_REG;

  assign unused_fwd_state = ^{wb_q, mem_q.is_load, ex_rs1_q, ex_rs2_q, ex_use_rs1_q, ex_use_rs2_q};
`endif

  // priority: memory wait freezes everything, then redirect, then data hazard
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    stall_w = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if (ex_redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign ex_bubble = flush_e || !id_valid;

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_use_rs1_d = ex_use_rs1_q;
    ex_use_rs2_d = ex_use_rs2_q;
    if (!mem_wait) begin
      wb_d         = mem_q;
      mem_d        = ex_q;
      ex_d         = ex_bubble ? SB_EMPTY : id_rec;
      ex_rs1_d     = id_rs1;
      ex_rs2_d     = id_rs2;
      ex_use_rs1_d = id_use_rs1 && !ex_bubble;
      ex_use_rs2_d = id_use_rs2 && !ex_bubble;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= SB_EMPTY;
      mem_q        <= SB_EMPTY;
      wb_q         <= SB_EMPTY;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_use_rs1_q <= 1'b0;
      ex_use_rs2_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_use_rs1_q <= ex_use_rs1_d;
      ex_use_rs2_q <= ex_use_rs2_d;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed hazard scenarios plus randomized traffic vs a pipeline model.
module tb_hazard_sequencer;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk, rst;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_write;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] id_result_src;
  logic       ex_redirect, dmem_ready;
  logic       stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e;
  logic [1:0] fwd_a_e, fwd_b_e;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  hazard_sequencer #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_result_src(id_result_src), .id_mem_write(id_mem_write),
    .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: instructions in flight, index 0 = EX, 1 = MEM, 2 = WB
  typedef struct {
    bit v;
    int rd, rs1, rs2;
    bit wr, ld, mm, u1, u2;
  } instr_t;

  instr_t pipe[3];

  function automatic bit writes(instr_t s);
    return s.v && s.wr && (s.rd != 0);
  endfunction

  function automatic bit id_needs(instr_t p);
    return id_valid && writes(p) &&
           ((id_use_rs1 && int'(id_rs1) == p.rd) || (id_use_rs2 && int'(id_rs2) == p.rd));
  endfunction

  function automatic int src_sel(int rs, bit used);
    if (!FWD || !used) return 0;
    if (writes(pipe[1]) && !pipe[1].ld && pipe[1].rd == rs) return 2;
    if (writes(pipe[2]) && pipe[2].rd == rs) return 1;
    return 0;
  endfunction

  // expected {stall_f,stall_d,stall_e,stall_m,stall_w,flush_d,flush_e}
  function automatic logic [6:0] exp_ctl();
    bit waiting, hz;
    waiting = pipe[1].v && pipe[1].mm && !dmem_ready;
    hz = FWD ? (id_needs(pipe[0]) && pipe[0].ld) : (id_needs(pipe[0]) || id_needs(pipe[1]));
    if (waiting) return 7'b1111100;
    if (ex_redirect) return 7'b0000011;
    if (hz) return 7'b1100001;
    return 7'b0000000;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [6:0] c;
    instr_t nw;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
    end else begin
      c = exp_ctl();
      if (!c[2]) begin
        nw = '{default: 0};
        if (id_valid && !c[0]) begin
          nw.v = 1; nw.rd = id_rd; nw.rs1 = id_rs1; nw.rs2 = id_rs2;
          nw.wr = id_reg_write; nw.ld = (id_result_src == 2'b01);
          nw.mm = (id_result_src == 2'b01) || id_mem_write;
          nw.u1 = id_use_rs1; nw.u2 = id_use_rs2;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nw;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("model_ctl", {1'b0, stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e}, {1'b0, exp_ctl()});
      chk("model_fwd_a", {6'd0, fwd_a_e}, 8'(src_sel(pipe[0].rs1, pipe[0].v && pipe[0].u1)));
      chk("model_fwd_b", {6'd0, fwd_b_e}, 8'(src_sel(pipe[0].rs2, pipe[0].v && pipe[0].u2)));
    end
  end

  task automatic drv(bit v, int rd, int rs1, int rs2, bit u1, bit u2, bit wr, int rsrc, bit mw);
    id_valid = v; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = wr;
    id_result_src = 2'(rsrc); id_mem_write = mw;
  endtask

  task automatic idle();                      drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic add(int rd, int a, int b);   drv(1, rd, a, b, 1, 1, 1, 0, 0); endtask
  task automatic lw(int rd, int a);           drv(1, rd, a, 0, 1, 0, 1, 1, 0); endtask
  task automatic sw(int a, int b);            drv(1, 0, a, b, 1, 1, 0, 0, 1); endtask
  task automatic cyc();                       @(posedge clk); #1; endtask
  task automatic ckpt();                      @(negedge clk); endtask
  task automatic drain();                     idle(); repeat (4) cyc(); endtask

  function automatic logic [7:0] ctl_now();
    return {1'b0, stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e};
  endfunction

  initial begin
    rst = 1'b1; ex_redirect = 1'b0; dmem_ready = 1'b1;
    idle();
    repeat (2) begin
      ckpt();
      chk("reset_ctl", ctl_now(), 8'h00);
      chk("reset_fwd", {4'd0, fwd_a_e, fwd_b_e}, 8'h00);
    end
    @(posedge clk); #1 rst = 1'b0;
    cmp_en = 1'b1;
    drain();

    // back-to-back producer/consumer
    add(5, 1, 2); cyc(); add(6, 5, 1); cyc(); idle(); ckpt();
    chk("b2b_fwd_a", {6'd0, fwd_a_e}, FWD ? 8'd2 : 8'd0);
    drain();

    // one unrelated instruction in between
    add(5, 1, 2); cyc(); add(9, 3, 4); cyc(); add(6, 5, 1); cyc(); idle(); ckpt();
    chk("gap1_fwd_a", {6'd0, fwd_a_e}, FWD ? 8'd1 : 8'd0);
    drain();

    // load-use
    lw(7, 1); cyc(); add(8, 7, 7); ckpt();
    chk("lu_ctl", ctl_now(), 8'b0110_0001);
    cyc(); ckpt();
    chk("lu_release", {7'd0, stall_f}, FWD ? 8'd0 : 8'd1);
    repeat (FWD ? 0 : 1) cyc();
    cyc(); idle(); ckpt();
    chk("lu_fwd_a", {6'd0, fwd_a_e}, FWD ? 8'd1 : 8'd0);
    chk("lu_fwd_b", {6'd0, fwd_b_e}, FWD ? 8'd1 : 8'd0);
    drain();

    // rs2 matches a load but is not read
    lw(7, 1); cyc(); drv(1, 8, 1, 7, 1, 0, 1, 0, 0); ckpt();
    chk("rs2_unused_stall", {7'd0, stall_f}, 8'd0);
    drain();

    // x0 never stalls or forwards
    lw(0, 1); cyc(); add(8, 0, 0); ckpt();
    chk("x0_stall", ctl_now(), 8'h00);
    cyc(); idle(); ckpt();
    chk("x0_fwd", {4'd0, fwd_a_e, fwd_b_e}, 8'h00);
    drain();

    // store stuck in MEM while EX wants to redirect
    sw(1, 2); cyc(); idle(); cyc();
    dmem_ready = 1'b0; ex_redirect = 1'b1;
    repeat (3) begin
      ckpt();
      chk("memwait_ctl", ctl_now(), 8'b0111_1100);
      cyc();
    end
    dmem_ready = 1'b1; ckpt();
    chk("memwait_redirect", ctl_now(), 8'b0000_0011);
    cyc(); ex_redirect = 1'b0;
    drain();

    // redirect beats a simultaneous load-use
    lw(7, 1); cyc(); add(8, 7, 7); ex_redirect = 1'b1; ckpt();
    chk("redir_over_lu", ctl_now(), 8'b0000_0011);
    cyc(); ex_redirect = 1'b0;
    drain();

    // add after add: two RAW stall cycles when forwarding is absent
    add(5, 1, 2); cyc(); add(6, 5, 1); ckpt();
    chk("raw_stall_1", {7'd0, stall_f}, FWD ? 8'd0 : 8'd1);
    cyc(); ckpt();
    chk("raw_stall_2", {7'd0, stall_f}, FWD ? 8'd0 : 8'd1);
    cyc(); ckpt();
    chk("raw_stall_3", {7'd0, stall_f}, 8'd0);
    cyc(); idle(); ckpt();
    chk("raw_fwd_a", {6'd0, fwd_a_e}, 8'd0);
    drain();

    // asynchronous reset during a load wait
    lw(7, 1); cyc(); idle(); cyc(); dmem_ready = 1'b0; ckpt();
    chk("pre_rst_wait", {7'd0, stall_m}, 8'd1);
    #1 rst = 1'b1;
    #1 chk("rst_async_ctl", ctl_now(), 8'h00);
    @(posedge clk); #1 rst = 1'b0; dmem_ready = 1'b1; ckpt();
    chk("post_rst_ctl", ctl_now(), 8'h00);
    chk("post_rst_fwd", {4'd0, fwd_a_e, fwd_b_e}, 8'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i == 1500) begin
        rst = 1'b1; #2 rst = 1'b0;
      end
      drv($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
          $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      dmem_ready  = ($urandom_range(0, 3) != 0);
    end
    cyc();
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
